// File: rtl/weight_stream_ctrl_pkg.sv
// Shared types for the weight stream controller.
//   ws_state_t : controller FSM state (IDLE, FETCH, DRAIN)
package weight_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } ws_state_t;

endpackage

// File: rtl/weight_stream_ctrl_if.sv
// Bus bundle between the weight stream controller, the weight ROM and the consumer.
//   rom_addr/rom_ce/rom_q : pipelined ROM read port (registered address, fixed latency)
//   data_out*             : output stream
// Handshake: a beat transfers in any cycle where data_out_valid & data_out_ready are
// both high. Once valid is raised it stays high, and data_out/data_out_last stay
// unchanged, until that beat transfers. valid never depends on ready.
// modport master : controller side; modport slave : ROM + consumer side.
interface weight_stream_ctrl_if #(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 6
);
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic                  rom_ce;
  logic [DATA_WIDTH-1:0] rom_q;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_out_last;
  logic                  data_out_valid;
  logic                  data_out_ready;

  modport master (
    output rom_addr, rom_ce, data_out, data_out_last, data_out_valid,
    input  rom_q, data_out_ready
  );

  modport slave (
    input  rom_addr, rom_ce, data_out, data_out_last, data_out_valid,
    output rom_q, data_out_ready
  );
endinterface

// File: rtl/weight_stream_ctrl_fifo.sv
// Synchronous first-word-fall-through FIFO. The head word is read straight from the
// storage flops, so a word written in cycle t is visible on o_dout in cycle t+1.
// A push while full is accepted only when a pop happens in the same cycle.
//   clk, rst  : clock, synchronous active-high reset
//   i_push/i_din, i_pop : write and read requests
//   o_dout    : head word (meaningful when !o_empty)
//   o_count, o_full, o_empty : occupancy status
module weight_stream_fifo #(
  parameter int DEPTH = 3,
  parameter int WIDTH = 513
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_push,
  input  logic [WIDTH-1:0]             i_din,
  input  logic                         i_pop,
  output logic [WIDTH-1:0]             o_dout,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_full,
  output logic                         o_empty
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // Depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign o_count   = r_count;
  assign o_dout    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  // Storage carries data only; its contents are qualified by r_count.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end
endmodule

// File: rtl/weight_stream_ctrl.sv
// Weight stream controller: on start, reads the whole tensor (OUT_DEPTH words) from a
// pipelined ROM repeat_count times and streams it to a valid/ready consumer.
// Reads are issued only when a FIFO slot is guaranteed for the returning word
// (in-flight reads + buffered words never exceed FIFO_DEPTH), so backpressure never
// loses data, while a held-high ready still gives one word per cycle.
//   clk, rst          : clock, synchronous active-high reset (aborts a run, no done)
//   start, repeat_count : run request, sampled only in IDLE
//   busy, done        : run in progress / one-cycle completion pulse
//   bus               : ROM read port and output stream (master side)
//   o_dbg_*           : FSM state, in-flight reads, FIFO occupancy and full flag
module weight_stream_ctrl
  import weight_stream_pkg::*;
#(
  parameter int DATA_WIDTH   = 512,
  parameter int OUT_DEPTH    = 32,
  parameter int ROM_LATENCY  = 2,
  parameter int REPEAT_WIDTH = 16,
  parameter int ADDR_WIDTH   = $clog2(OUT_DEPTH) + 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [REPEAT_WIDTH-1:0]             repeat_count,
  output logic                                busy,
  output logic                                done,
  weight_stream_ctrl_if.master                bus,
  output ws_state_t                           o_dbg_state,
  output logic [$clog2(ROM_LATENCY+2)-1:0]    o_dbg_inflight,
  output logic [$clog2(ROM_LATENCY+2)-1:0]    o_dbg_fifo_count,
  output logic                                o_dbg_fifo_full
);
  localparam int FIFO_DEPTH = ROM_LATENCY + 1;
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

  ws_state_t              r_state;
  logic                   r_busy;
  logic                   r_done;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [REPEAT_WIDTH-1:0] r_pass;
  logic [REPEAT_WIDTH-1:0] r_repeat;
  logic [CNT_W-1:0]       r_inflight;
  logic [ROM_LATENCY-1:0] r_pipe_vld;
  logic [ROM_LATENCY-1:0] r_pipe_last;

  logic                   w_pop;
  logic                   w_push;
  logic                   w_issue;
  logic                   w_last_addr;
  logic                   w_final_pop;
  logic [CNT_W:0]         w_occ;
  logic [CNT_W-1:0]       w_fifo_count;
  logic                   w_fifo_full;
  logic                   w_fifo_empty;
  logic [DATA_WIDTH:0]    w_fifo_dout;

  assign w_pop       = !w_fifo_empty && bus.data_out_ready;
  assign w_push      = r_pipe_vld[ROM_LATENCY-1];
  // A word popped this cycle frees its slot in time for a read issued now.
  assign w_occ       = (CNT_W+1)'(r_inflight) + (CNT_W+1)'(w_fifo_count) - (CNT_W+1)'(w_pop);
  assign w_issue     = (r_state == FETCH) && (w_occ < (CNT_W+1)'(FIFO_DEPTH));
  assign w_last_addr = (r_addr == ADDR_WIDTH'(OUT_DEPTH - 1));
  // The run is over when the only word left anywhere transfers this cycle.
  assign w_final_pop = w_pop && (w_fifo_count == CNT_W'(1)) && (r_inflight == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_addr      <= '0;
      r_pass      <= '0;
      r_repeat    <= '0;
      r_inflight  <= '0;
      r_pipe_vld  <= '0;
      r_pipe_last <= '0;
    end else begin
      r_done <= 1'b0;

      // Tag pipe runs alongside the ROM pipeline; its tail marks a valid rom_q.
      r_pipe_vld[0]  <= w_issue;
      r_pipe_last[0] <= w_last_addr;
      for (int i = 1; i < ROM_LATENCY; i++) begin
        r_pipe_vld[i]  <= r_pipe_vld[i-1];
        r_pipe_last[i] <= r_pipe_last[i-1];
      end
      r_inflight <= r_inflight + CNT_W'(w_issue) - CNT_W'(w_push);

      case (r_state)
        IDLE: begin
          if (start) begin
            if (repeat_count != '0) begin
              r_repeat <= repeat_count;
              r_pass   <= '0;
              r_addr   <= '0;
              r_busy   <= 1'b1;
              r_state  <= FETCH;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        FETCH: begin
          if (w_issue) begin
            if (w_last_addr) begin
              r_addr <= '0;
              if (r_pass == r_repeat - REPEAT_WIDTH'(1)) r_state <= DRAIN;
              else r_pass <= r_pass + REPEAT_WIDTH'(1);
            end else begin
              r_addr <= r_addr + ADDR_WIDTH'(1);
            end
          end
        end
        DRAIN: begin
          if (w_final_pop) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  weight_stream_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_WIDTH + 1)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_din   ({r_pipe_last[ROM_LATENCY-1], bus.rom_q}),
    .i_pop   (w_pop),
    .o_dout  (w_fifo_dout),
    .o_count (w_fifo_count),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign busy               = r_busy;
  assign done               = r_done;
  assign bus.rom_addr       = r_addr;
  assign bus.rom_ce         = 1'b1;
  assign bus.data_out       = w_fifo_dout[DATA_WIDTH-1:0];
  assign bus.data_out_last  = !w_fifo_empty && w_fifo_dout[DATA_WIDTH];
  assign bus.data_out_valid = !w_fifo_empty;
  assign o_dbg_state        = r_state;
  assign o_dbg_inflight     = r_inflight;
  assign o_dbg_fifo_count   = w_fifo_count;
  assign o_dbg_fifo_full    = w_fifo_full;
endmodule

// File: tb/tb_weight_stream_ctrl.sv
module tb_weight_stream_ctrl;
  import weight_stream_pkg::*;

  localparam int DW  = 32;
  localparam int OD  = 4;
  localparam int LAT = 2;
  localparam int RW  = 16;
  localparam int AW  = $clog2(OD) + 1;
  localparam int CW  = $clog2(LAT + 2);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          start = 1'b0;
  logic [RW-1:0] repeat_count = '0;
  logic          busy;
  logic          done;
  ws_state_t     dbg_state;
  logic [CW-1:0] dbg_inflight;
  logic [CW-1:0] dbg_fifo_count;
  logic          dbg_fifo_full;

  weight_stream_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  weight_stream_ctrl #(
    .DATA_WIDTH(DW), .OUT_DEPTH(OD), .ROM_LATENCY(LAT), .REPEAT_WIDTH(RW), .ADDR_WIDTH(AW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .repeat_count     (repeat_count),
    .busy             (busy),
    .done             (done),
    .bus              (bus.master),
    .o_dbg_state      (dbg_state),
    .o_dbg_inflight   (dbg_inflight),
    .o_dbg_fifo_count (dbg_fifo_count),
    .o_dbg_fifo_full  (dbg_fifo_full)
  );

  // ROM model: address k returns k, LAT cycles after the address is presented.
  logic [AW-1:0] rom_pipe [LAT];
  always @(posedge clk) begin
    rom_pipe[0] <= bus.rom_addr;
    for (int i = 1; i < LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
  end
  assign bus.rom_q = DW'(rom_pipe[LAT-1]);

  initial bus.data_out_ready = 1'b0;

  // ---------------- scoreboard ----------------
  logic [DW:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;
  int xfer_count = 0;
  int last_xfer_cyc = -1;
  bit prev_stall = 1'b0;
  logic [DW:0] prev_word;

  // Reference model: a run streams repeat passes of words 0..OD-1, last on OD-1.
  task automatic model_run(input int reps);
    for (int p = 0; p < reps; p++)
      for (int k = 0; k < OD; k++)
        exp_q.push_back({(k == OD - 1), DW'(k)});
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.data_out_valid && bus.data_out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_word: got %0h last=%0b with nothing expected",
                   bus.data_out, bus.data_out_last);
        end else begin
          logic [DW:0] e;
          e = exp_q.pop_front();
          if ({bus.data_out_last, bus.data_out} !== e) begin
            n_fail++;
            $display("FAIL word_order: got last=%0b data=%0h expected last=%0b data=%0h",
                     bus.data_out_last, bus.data_out, e[DW], e[DW-1:0]);
          end
        end
        xfer_count++;
        last_xfer_cyc = cyc;
      end
      if (prev_stall) begin
        n_checks++;
        if (!bus.data_out_valid || {bus.data_out_last, bus.data_out} !== prev_word) begin
          n_fail++;
          $display("FAIL stall_hold: got valid=%0b word=%0h expected valid=1 word=%0h",
                   bus.data_out_valid, {bus.data_out_last, bus.data_out}, prev_word);
        end
      end
      prev_stall = bus.data_out_valid && !bus.data_out_ready;
      prev_word  = {bus.data_out_last, bus.data_out};
      n_checks++;
      if (int'(dbg_inflight) + int'(dbg_fifo_count) > LAT + 1) begin
        n_fail++;
        $display("FAIL credit_bound: got inflight+fifo=%0d expected <= %0d",
                 int'(dbg_inflight) + int'(dbg_fifo_count), LAT + 1);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input int reps);
    start        = 1'b1;
    repeat_count = RW'(reps);
    tick();
    start        = 1'b0;
  endtask

  // Waits for done; ready randomised when rand_ready is set. done_cyc=-1 on timeout.
  task automatic run_until_done(input int budget, input bit rand_ready, output int done_cyc);
    done_cyc = -1;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        done_cyc = cyc;
        return;
      end
      if (rand_ready) bus.data_out_ready = 1'($urandom_range(0, 1));
      tick();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_checks++;
    if ({busy, done, bus.data_out_valid, bus.data_out_last} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy/done/valid/last=%b expected 0000",
               {busy, done, bus.data_out_valid, bus.data_out_last});
    end
    n_checks++;
    if (bus.rom_addr !== '0 || bus.rom_ce !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_rom: got addr=%0d ce=%0b expected addr=0 ce=1", bus.rom_addr, bus.rom_ce);
    end
    n_checks++;
    if (dbg_state !== IDLE) begin
      n_fail++;
      $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE);
    end
    rst = 1'b0;
    mon_en = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    int c0, dc;
    bus.data_out_ready = 1'b1;
    model_run(2);
    c0 = cyc;
    start_run(2);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_busy: got %0b expected 1", busy);
    end
    while (cyc < c0 + 4) begin
      n_checks++;
      if (bus.data_out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_early_valid: got valid=1 at cycle +%0d expected 0", cyc - c0);
      end
      tick();
    end
    n_checks++;
    if (bus.data_out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_first_valid: got %0b at cycle +4 expected 1", bus.data_out_valid);
    end
    run_until_done(60, 1'b0, dc);
    n_checks++;
    if (last_xfer_cyc != c0 + 11 || dc != c0 + 12) begin
      n_fail++;
      $display("FAIL b2b_timing: got last_xfer=+%0d done=+%0d expected +11 and +12",
               last_xfer_cyc - c0, dc - c0);
    end
    n_checks++;
    if (busy !== 1'b0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_end: got busy=%0b pending=%0d expected busy=0 pending=0", busy, exp_q.size());
    end
    tick();
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_done_pulse: got done=%0b one cycle later expected 0", done);
    end
  endtask

  task automatic test_zero_repeat();
    bit seen_valid;
    bus.data_out_ready = 1'b1;
    start_run(0);
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_done: got done=%0b busy=%0b expected done=1 busy=0", done, busy);
    end
    seen_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.data_out_valid) seen_valid = 1'b1;
    end
    n_checks++;
    if (seen_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_no_words: got valid seen=1 expected 0");
    end
  endtask

  task automatic test_random_ready();
    int base, dc;
    base = xfer_count;
    model_run(3);
    start_run(3);
    run_until_done(400, 1'b1, dc);
    n_checks++;
    if (dc < 0) begin
      n_fail++;
      $display("FAIL rand_timeout: got no done in 400 cycles expected done");
    end
    n_checks++;
    if (xfer_count - base != 3 * OD || (dc >= 0 && dc != last_xfer_cyc + 1)) begin
      n_fail++;
      $display("FAIL rand_count: got %0d words done_at=%0d expected %0d words done_at=%0d",
               xfer_count - base, dc, 3 * OD, last_xfer_cyc + 1);
    end
    bus.data_out_ready = 1'b1;
    tick();
  endtask

  task automatic test_backpressure();
    int dc;
    bus.data_out_ready = 1'b0;
    model_run(1);
    start_run(1);
    for (int i = 0; i < 10; i++) tick();
    n_checks++;
    if (dbg_fifo_count !== CW'(3) || dbg_inflight !== '0 || dbg_fifo_full !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_stall_fill: got fifo=%0d inflight=%0d full=%0b expected 3 0 1",
               dbg_fifo_count, dbg_inflight, dbg_fifo_full);
    end
    n_checks++;
    if (bus.rom_addr !== AW'(3)) begin
      n_fail++;
      $display("FAIL bp_issued: got next addr=%0d expected 3 (three reads)", bus.rom_addr);
    end
    n_checks++;
    if (bus.data_out_valid !== 1'b1 || bus.data_out !== DW'(0)) begin
      n_fail++;
      $display("FAIL bp_head: got valid=%0b data=%0h expected valid=1 data=0",
               bus.data_out_valid, bus.data_out);
    end
    bus.data_out_ready = 1'b1;
    run_until_done(60, 1'b0, dc);
    n_checks++;
    if (dc < 0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL bp_resume: got done_at=%0d pending=%0d expected done and 0 pending", dc, exp_q.size());
    end
    tick();
  endtask

  task automatic test_reset_mid_run();
    int base, dc;
    bit seen_done;
    bus.data_out_ready = 1'b1;
    model_run(2);
    base = xfer_count;
    start_run(2);
    for (int i = 0; i < 40 && xfer_count - base < 2; i++) tick();
    rst = 1'b1;
    bus.data_out_ready = 1'b0;
    mon_en = 1'b0;
    tick();
    rst = 1'b0;
    exp_q.delete();
    prev_stall = 1'b0;
    n_checks++;
    if (bus.data_out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || dbg_state !== IDLE) begin
      n_fail++;
      $display("FAIL abort_state: got valid=%0b busy=%0b done=%0b state=%0d expected 0 0 0 IDLE",
               bus.data_out_valid, busy, done, dbg_state);
    end
    mon_en = 1'b1;
    bus.data_out_ready = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done) seen_done = 1'b1;
    end
    n_checks++;
    if (seen_done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_no_done: got done pulse expected none");
    end
    base = xfer_count;
    model_run(1);
    start_run(1);
    run_until_done(60, 1'b0, dc);
    n_checks++;
    if (dc < 0 || xfer_count - base != OD || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL abort_restart: got done_at=%0d words=%0d expected done and %0d words",
               dc, xfer_count - base, OD);
    end
    tick();
  endtask

  task automatic test_start_while_busy();
    int base, dc;
    bus.data_out_ready = 1'b1;
    base = xfer_count;
    model_run(1);
    start_run(1);
    tick();
    start_run(3);
    run_until_done(60, 1'b0, dc);
    for (int i = 0; i < 10; i++) tick();
    n_checks++;
    if (dc < 0 || xfer_count - base != OD || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_start: got done_at=%0d words=%0d busy=%0b expected done, %0d words, busy=0",
               dc, xfer_count - base, busy, OD);
    end
  endtask

  task automatic test_random_runs();
    int base, dc, reps;
    for (int r = 0; r < 4; r++) begin
      reps = $urandom_range(1, 4);
      base = xfer_count;
      model_run(reps);
      start_run(reps);
      run_until_done(500, 1'b1, dc);
      n_checks++;
      if (dc < 0 || xfer_count - base != reps * OD || exp_q.size() != 0) begin
        n_fail++;
        $display("FAIL random_run: got done_at=%0d words=%0d expected done and %0d words",
                 dc, xfer_count - base, reps * OD);
      end
      bus.data_out_ready = 1'b1;
      tick();
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_back_to_back();
    test_zero_repeat();
    test_random_ready();
    test_backpressure();
    test_reset_mid_run();
    test_start_while_busy();
    test_random_runs();
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
